// File: rtl/pe_pkg.sv
// Shared definitions for the parametrised PE group: mode codes, FSM states
// and the accumulator width rule.
package pe_pkg;

    localparam logic [1:0] MODE_SINGLE  = 2'd0;
    localparam logic [1:0] MODE_SPLIT   = 2'd1;
    localparam logic [1:0] MODE_STRIDE2 = 2'd2;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Wide enough that the sum of every product in the group cannot overflow.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned ww,
                                              input int unsigned taps, input int unsigned rows);
        return dw + ww + $clog2(taps * rows);
    endfunction

endpackage

// File: rtl/pe_group_param_if.sv
// Weight-load, ifmap and result signals of one PE group.
interface pe_group_param_if #(
    parameter int unsigned DW    = 8,
    parameter int unsigned WW    = 8,
    parameter int unsigned ROWS  = 2,
    parameter int unsigned ACC_W = 20
);
    logic [1:0]            mode;
    logic                  clear;
    logic                  w_valid;
    logic [WW-1:0]         w_data;
    logic                  w_ready;
    logic                  w_loaded;
    logic                  in_valid;
    logic [ROWS*DW-1:0]    in_data;
    logic [ROWS*DW-1:0]    in_data_odd;
    logic                  out_valid;
    logic [ROWS*ACC_W-1:0] out_sum;

    modport master (
        output mode, clear, w_valid, w_data, in_valid, in_data, in_data_odd,
        input  w_ready, w_loaded, out_valid, out_sum
    );

    modport slave (
        input  mode, clear, w_valid, w_data, in_valid, in_data, in_data_odd,
        output w_ready, w_loaded, out_valid, out_sum
    );
endinterface

// File: rtl/pe_group_param_row.sv
// One row: sliding sample window, registered per-tap products and a
// registered row sum. Tap 0 holds the oldest sample.
module pe_row #(
    parameter int unsigned DW    = 8,
    parameter int unsigned WW    = 8,
    parameter int unsigned TAPS  = 5,
    parameter int unsigned ACC_W = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic                    shift_i,
    input  logic                    stride2_i,
    input  logic                    prod_en_i,
    input  logic [DW-1:0]           din_i,
    input  logic [DW-1:0]           din_odd_i,
    input  logic [TAPS*WW-1:0]      weights_i,
    output logic signed [ACC_W-1:0] row_sum_o
);
    localparam int unsigned PW = DW + WW;

    logic signed [DW-1:0]    win_q  [TAPS];
    logic signed [PW-1:0]    prod_d [TAPS];
    logic signed [PW-1:0]    prod_q [TAPS];
    logic signed [ACC_W-1:0] sum_d;
    logic signed [ACC_W-1:0] row_sum_q;

    // Window shift: one new sample, or an even/odd pair in stride-2 mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) win_q[k] <= '0;
        end else if (clear_i) begin
            for (int k = 0; k < TAPS; k++) win_q[k] <= '0;
        end else if (shift_i) begin
            if (stride2_i) begin
                for (int k = 0; k < TAPS - 2; k++) win_q[k] <= win_q[k+2];
                win_q[TAPS-2] <= din_i;
                win_q[TAPS-1] <= din_odd_i;
            end else begin
                for (int k = 0; k < TAPS - 1; k++) win_q[k] <= win_q[k+1];
                win_q[TAPS-1] <= din_i;
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < TAPS; k++) begin
            prod_d[k] = PW'(win_q[k]) * PW'($signed(weights_i[k*WW +: WW]));
            sum_d     = sum_d + ACC_W'(prod_q[k]);
        end
    end

    // Products are zeroed for beats that do not produce a result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
            row_sum_q <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) prod_q[k] <= prod_en_i ? prod_d[k] : '0;
            row_sum_q <= sum_d;
        end
    end

    assign row_sum_o = row_sum_q;
endmodule

// File: rtl/pe_group_param.sv
// PE group top: weight-load FSM, window fill tracking, result valid pipeline
// and the SINGLE/per-row output combine around ROWS pe_row instances.
module pe_group_param
    import pe_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned WW    = 8,
    parameter int unsigned TAPS  = 5,
    parameter int unsigned ROWS  = 2,
    parameter int unsigned ACC_W = acc_width(DW, WW, TAPS, ROWS)
) (
    input logic              clk,
    input logic              rst_n,
    pe_group_param_if.slave  bus
);
    localparam int unsigned NW     = ROWS * TAPS;
    localparam int unsigned IDX_W  = $clog2(NW);
    localparam int unsigned FILL_W = $clog2(TAPS + 3);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        w_idx_q, w_idx_d;
    logic [1:0]              mode_q, mode_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic                    w_we_c, accept_c, v0_d, stride2_c;
    logic                    v0_q, v1_q, v2_q, out_valid_q;
    logic                    w_ready_q, w_loaded_q;
    logic [WW-1:0]           w_q [NW];
    logic [ROWS*ACC_W-1:0]   out_sum_q, out_sum_d;
    logic signed [ACC_W-1:0] row_sum [ROWS];
    logic signed [ACC_W-1:0] total_c;

    assign stride2_c = (mode_q == MODE_STRIDE2);

    // Next-state: clear dominates; LOAD counts weights, RUN tracks window fill
    always_comb begin
        state_d  = state_q;
        w_idx_d  = w_idx_q;
        mode_d   = mode_q;
        fill_d   = fill_q;
        w_we_c   = 1'b0;
        accept_c = 1'b0;
        v0_d     = 1'b0;
        if (bus.clear) begin
            state_d = ST_LOAD;
            w_idx_d = '0;
            fill_d  = '0;
        end else if (state_q == ST_LOAD) begin
            if (bus.w_valid) begin
                w_we_c = 1'b1;
                if (w_idx_q == IDX_W'(NW - 1)) begin
                    state_d = ST_RUN;
                    w_idx_d = '0;
                    mode_d  = bus.mode;
                end else begin
                    w_idx_d = w_idx_q + IDX_W'(1);
                end
            end
        end else if (bus.in_valid) begin
            accept_c = 1'b1;
            fill_d   = fill_q + (stride2_c ? FILL_W'(2) : FILL_W'(1));
            if (fill_d > FILL_W'(TAPS)) fill_d = FILL_W'(TAPS);
            v0_d     = (fill_d == FILL_W'(TAPS));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            w_idx_q     <= '0;
            mode_q      <= MODE_SINGLE;
            fill_q      <= '0;
            w_ready_q   <= 1'b1;
            w_loaded_q  <= 1'b0;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            for (int i = 0; i < NW; i++) w_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            w_idx_q     <= w_idx_d;
            mode_q      <= mode_d;
            fill_q      <= fill_d;
            w_ready_q   <= (state_d == ST_LOAD);
            w_loaded_q  <= (state_d == ST_RUN);
            v0_q        <= v0_d;
            v1_q        <= v0_q & ~bus.clear;
            v2_q        <= v1_q & ~bus.clear;
            out_valid_q <= v2_q & ~bus.clear;
            if (v2_q && !bus.clear) out_sum_q <= out_sum_d;
            if (w_we_c) w_q[w_idx_q] <= bus.w_data;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [TAPS*WW-1:0] wrow;
        always_comb begin
            for (int k = 0; k < TAPS; k++) wrow[k*WW +: WW] = w_q[r*TAPS + k];
        end
        pe_row #(.DW(DW), .WW(WW), .TAPS(TAPS), .ACC_W(ACC_W)) u_row (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear_i   (bus.clear),
            .shift_i   (accept_c),
            .stride2_i (stride2_c),
            .prod_en_i (v0_q),
            .din_i     (bus.in_data[r*DW +: DW]),
            .din_odd_i (bus.in_data_odd[r*DW +: DW]),
            .weights_i (wrow),
            .row_sum_o (row_sum[r])
        );
    end

    // SINGLE folds all rows into slice 0; other modes present one sum per row
    always_comb begin
        out_sum_d = '0;
        total_c   = '0;
        for (int r = 0; r < ROWS; r++) total_c = total_c + row_sum[r];
        if (mode_q == MODE_SINGLE) begin
            out_sum_d[0 +: ACC_W] = total_c;
        end else begin
            for (int r = 0; r < ROWS; r++) out_sum_d[r*ACC_W +: ACC_W] = row_sum[r];
        end
    end

    assign bus.w_ready   = w_ready_q;
    assign bus.w_loaded  = w_loaded_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
endmodule

// File: tb/tb_pe_group_param.sv
// Randomised bench for pe_group_param: a sample-history reference model
// predicts results into a scoreboard drained by an output monitor.
module tb_pe_group_param;
    import pe_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned WW    = 8;
    localparam int unsigned TAPS  = 5;
    localparam int unsigned ROWS  = 2;
    localparam int unsigned ACC_W = acc_width(DW, WW, TAPS, ROWS);
    localparam int unsigned NW    = ROWS * TAPS;
    localparam int unsigned IW    = ROWS * DW;
    localparam int unsigned OW    = ROWS * ACC_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pe_group_param_if #(.DW(DW), .WW(WW), .ROWS(ROWS), .ACC_W(ACC_W)) bus ();

    pe_group_param #(.DW(DW), .WW(WW), .TAPS(TAPS), .ROWS(ROWS), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Reference model state
    int         wm [NW];
    int         widx_m = 0;
    bit         run_m  = 1'b0;
    logic [1:0] mode_m = MODE_SINGLE;
    int         hist [ROWS][$];
    int         wl [NW];

    logic [OW-1:0] exp_sum_q [$];
    int            exp_cyc_q [$];
    logic [OW-1:0] last_out = '0;

    function automatic int sx(input logic [DW-1:0] v);
        logic signed [DW-1:0] t;
        t = v;
        return int'(t);
    endfunction

    function automatic int slice_of(input int r);
        logic signed [ACC_W-1:0] t;
        t = last_out[r*ACC_W +: ACC_W];
        return int'(t);
    endfunction

    function automatic logic [IW-1:0] rep(input int v);
        logic [IW-1:0] x;
        for (int r = 0; r < ROWS; r++) x[r*DW +: DW] = DW'(v);
        return x;
    endfunction

    // Applies the rules to the inputs sampled at the current active edge
    task automatic model_step();
        logic [OW-1:0] ev;
        int s, tot;
        if (bus.clear) begin
            run_m  = 1'b0;
            widx_m = 0;
            for (int r = 0; r < ROWS; r++) hist[r].delete();
            exp_sum_q.delete();
            exp_cyc_q.delete();
        end else if (!run_m) begin
            if (bus.w_valid) begin
                wm[widx_m] = sx(bus.w_data);
                if (widx_m == NW - 1) begin
                    run_m  = 1'b1;
                    widx_m = 0;
                    mode_m = bus.mode;
                end else begin
                    widx_m++;
                end
            end
        end else if (bus.in_valid) begin
            for (int r = 0; r < ROWS; r++) begin
                hist[r].push_back(sx(bus.in_data[r*DW +: DW]));
                if (mode_m == MODE_STRIDE2) hist[r].push_back(sx(bus.in_data_odd[r*DW +: DW]));
                while (hist[r].size() > TAPS) void'(hist[r].pop_front());
            end
            if (hist[0].size() == TAPS) begin
                ev  = '0;
                tot = 0;
                for (int r = 0; r < ROWS; r++) begin
                    s = 0;
                    for (int k = 0; k < TAPS; k++) s += wm[r*TAPS + k] * hist[r][k];
                    tot += s;
                    if (mode_m != MODE_SINGLE) ev[r*ACC_W +: ACC_W] = ACC_W'(s);
                end
                if (mode_m == MODE_SINGLE) ev[0 +: ACC_W] = ACC_W'(tot);
                exp_sum_q.push_back(ev);
                exp_cyc_q.push_back(cyc + 3);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        vectors++;
        if (bus.w_ready !== ~run_m || bus.w_loaded !== run_m) begin
            errors++;
            $display("FAIL handshake cyc=%0d w_ready=%b w_loaded=%b required %b %b",
                     cyc, bus.w_ready, bus.w_loaded, ~run_m, run_m);
        end
    endtask

    task automatic chk(input string nm, input int got, input int want);
        vectors++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d required %0d", nm, got, want);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.w_valid  = 1'b0;
        bus.clear    = 1'b0;
        repeat (n) tick();
    endtask

    task automatic beat(input logic [IW-1:0] e, input logic [IW-1:0] o, input bit clr);
        bus.in_valid    = 1'b1;
        bus.in_data     = e;
        bus.in_data_odd = o;
        bus.clear       = clr;
        tick();
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    // Loads wl[] with random w_valid gaps and ignored in_valid noise
    task automatic load(input logic [1:0] m);
        for (int i = 0; i < NW; i++) begin
            while ($urandom_range(2) == 0) begin
                bus.w_valid  = 1'b0;
                bus.w_data   = WW'($urandom);
                bus.in_valid = 1'($urandom_range(1));
                bus.in_data  = IW'($urandom);
                tick();
            end
            bus.w_valid  = 1'b1;
            bus.w_data   = WW'(wl[i]);
            bus.mode     = m;
            bus.in_valid = 1'b0;
            tick();
        end
        bus.w_valid = 1'b0;
    endtask

    task automatic rand_beats(input int n);
        repeat (n) begin
            if ($urandom_range(3) == 0) idle(1);
            beat(IW'($urandom), IW'($urandom), 1'b0);
        end
    endtask

    // Monitor: every out_valid must match the oldest prediction at its cycle
    always @(negedge clk) begin : monitor
        int ec;
        logic [OW-1:0] es;
        if (rst_n === 1'b1) begin
            if (bus.out_valid) begin
                vectors++;
                if (exp_sum_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out cyc=%0d out_sum=%h required no output", cyc, bus.out_sum);
                end else begin
                    es = exp_sum_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    if (ec != cyc || es !== bus.out_sum) begin
                        errors++;
                        $display("FAIL result cyc=%0d out_sum=%h required cyc=%0d out_sum=%h",
                                 cyc, bus.out_sum, ec, es);
                    end
                end
                last_out = bus.out_sum;
            end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
                vectors++;
                errors++;
                $display("FAIL missing_out cyc=%0d out_valid=0 required result %h",
                         cyc, exp_sum_q[0]);
                void'(exp_sum_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus.mode        = MODE_SINGLE;
        bus.clear       = 1'b0;
        bus.w_valid     = 1'b0;
        bus.w_data      = '0;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_data_odd = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_w_ready", int'(bus.w_ready), 1);
        chk("rst_w_loaded", int'(bus.w_loaded), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_sum_zero", int'(bus.out_sum == '0), 1);
        rst_n = 1'b1;
        repeat (3) beat(IW'($urandom), '0, 1'b0);

        // SPLIT with weights 1..10 and all-ones data
        for (int i = 0; i < NW; i++) wl[i] = i + 1;
        load(MODE_SPLIT);
        repeat (5) beat(rep(1), '0, 1'b0);
        idle(4);
        chk("split_row0", slice_of(0), 15);
        chk("split_row1", slice_of(1), 40);
        beat(rep(1), '0, 1'b0);
        idle(4);
        chk("split6_row0", slice_of(0), 15);
        chk("split6_row1", slice_of(1), 40);
        // w_valid while running must not disturb the weights
        bus.w_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.w_data = WW'($urandom);
            beat(IW'($urandom), '0, 1'b0);
        end
        bus.w_valid = 1'b0;
        rand_beats(20);
        idle(4);

        // SINGLE, same weights
        do_clear();
        load(MODE_SINGLE);
        repeat (5) beat(rep(1), '0, 1'b0);
        idle(4);
        chk("single_sum", slice_of(0), 55);
        chk("single_slice1", slice_of(1), 0);
        rand_beats(15);
        idle(4);

        // SINGLE extreme negative operands
        do_clear();
        for (int i = 0; i < NW; i++) wl[i] = -128;
        load(MODE_SINGLE);
        repeat (5) beat(rep(-128), rep(0), 1'b0);
        idle(4);
        chk("single_max", slice_of(0), 163840);
        chk("single_max_slice1", slice_of(1), 0);

        // STRIDE2: row0 weights all 1, row1 random
        do_clear();
        for (int i = 0; i < NW; i++) wl[i] = (i < TAPS) ? 1 : int'($urandom_range(255)) - 128;
        load(MODE_STRIDE2);
        for (int b = 0; b < 3; b++) begin
            logic [IW-1:0] e, o;
            e = IW'($urandom); o = IW'($urandom);
            e[0 +: DW] = DW'(2*b + 1);
            o[0 +: DW] = DW'(2*b + 2);
            beat(e, o, 1'b0);
        end
        idle(4);
        chk("stride2_first", slice_of(0), 20);
        begin
            logic [IW-1:0] e, o;
            e = IW'($urandom); o = IW'($urandom);
            e[0 +: DW] = DW'(7);
            o[0 +: DW] = DW'(8);
            beat(e, o, 1'b0);
        end
        idle(4);
        chk("stride2_next", slice_of(0), 30);
        rand_beats(15);
        idle(4);

        // clear coincident with the beat after the window fills
        do_clear();
        for (int i = 0; i < NW; i++) wl[i] = i + 1;
        load(MODE_SPLIT);
        repeat (5) beat(rep(1), '0, 1'b0);
        beat(rep(1), '0, 1'b1);
        chk("clear_w_ready", int'(bus.w_ready), 1);
        chk("clear_w_loaded", int'(bus.w_loaded), 0);
        idle(5);

        // Reload random weights in reserved mode (acts as SPLIT)
        for (int i = 0; i < NW; i++) wl[i] = int'($urandom_range(255)) - 128;
        load(2'd3);
        rand_beats(25);
        idle(6);

        vectors++;
        if (exp_sum_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required 0", exp_sum_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/pe_group_param.md
Name: pe_group_param

Overview:
- Parametrised successor of the fixed 6-weight PE group in the CNN accelerator datapath.
- Holds ROWS sliding ifmap windows of TAPS samples each, plus ROWS*TAPS signed weights.
- Computes a pipelined dot product per row, output as one combined sum (SINGLE) or as one sum per row (SPLIT).
- Adds a handshaked serial weight load, input/output valid tracking, window-fill tracking, a stride-2 window mode and a synchronous flush.

Parameters:
- DW, 8, ifmap sample width, signed.
- WW, 8, weight width, signed.
- TAPS, 5, window length per row; range 2..8.
- ROWS, 2, rows/channels per group; range 1..4.
- ACC_W, DW+WW+$clog2(TAPS*ROWS), signed output sum width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mode  in  2  0=SINGLE, 1=SPLIT, 2=STRIDE2 (per-row outputs, window shifts by 2), 3=reserved (behaves as SPLIT).
- clear  in  1  synchronous flush; returns block to weight load.
- w_valid  in  1  weight word valid.
- w_data  in  WW  weight word.
- w_ready  out  1  high while in LOAD.
- w_loaded  out  1  high while in RUN.
- in_valid  in  1  ifmap beat valid; no backpressure.
- in_data  in  ROWS*DW  row r sample at [r*DW +: DW]; even sample in STRIDE2.
- in_data_odd  in  ROWS*DW  odd sample per row; used only in STRIDE2.
- out_valid  out  1  one-cycle pulse per result.
- out_sum  out  ROWS*ACC_W  row r sum at [r*ACC_W +: ACC_W].

Behaviour:
- Reset values: state=LOAD, w_ready=1, w_loaded=0, out_valid=0, out_sum=0, all weights/windows/pipeline regs=0, fill=0, w_idx=0.
- FSM has two states, LOAD and RUN.
- LOAD:
  - Accept a weight when w_valid&&w_ready; store to weight[w_idx/TAPS][w_idx%TAPS] and increment w_idx.
  - Tap 0 multiplies the oldest window sample.
  - On accepting index ROWS*TAPS-1: latch mode, go to RUN, w_idx=0.
  - in_valid is ignored.
- RUN:
  - w_ready=0; w_valid is ignored.
  - mode is ignored; the latched mode applies. Mode changes only via clear and reload.
- clear (either state):
  - Next state LOAD; w_idx=0; fill=0; windows zeroed; all pipeline valid bits cleared, so in-flight results are squashed.
  - Weights are retained until overwritten.
  - clear wins over a simultaneous in_valid or w_valid; that beat is dropped.
- Window update on an accepted beat (RUN && in_valid && !clear):
  - Stride-1 modes: tap k <= tap k+1, tap TAPS-1 <= in_data; fill += 1.
  - STRIDE2: tap k <= tap k+2, tap TAPS-2 <= in_data, tap TAPS-1 <= in_data_odd; fill += 2.
  - fill saturates at TAPS.
- Pipeline (never stalls):
  - Cycle t: beat accepted. v0 = accept && fill_next >= TAPS.
  - t+1: per-tap products registered (2*... i.e. DW+WW bits, signed); products forced to 0 when v0=0.
  - t+2: per-row sums registered.
  - t+3: out_sum registered and out_valid=1.
- Latency is exactly 3 cycles from the accepting edge to out_valid; back-to-back beats give back-to-back results; gaps in in_valid give gaps in out_valid.
- out_sum when out_valid=0: holds its last value.
- Output by mode:
  - SINGLE: slice 0 = sum of all row sums; other slices = 0.
  - SPLIT/STRIDE2: slice r = row r sum.
- Arithmetic: all signed, sign-extended to ACC_W, no rounding/saturation; ACC_W guarantees no overflow.
- Window partially filled: no output. The first output follows the TAPS-th sample (stride-1) or the ceil(TAPS/2)-th beat (STRIDE2).
- Reset asserted mid-operation: immediate return to reset values.

Decomposition:
- Shared package pe_pkg holds:
  - Mode localparams MODE_SINGLE/MODE_SPLIT/MODE_STRIDE2.
  - FSM state encoding ST_LOAD/ST_RUN.
  - A function computing ACC_W from DW, WW, TAPS, ROWS.
- Sub-module pe_row, instantiated ROWS times. It contains one row's window shift register (stride select), TAPS multipliers and its adder-tree register stage.
- The top level owns the FSM, w_idx, fill, valid pipeline and output combine.

Test Plan:
- Reset with defaults (TAPS=5, ROWS=2) -> w_ready=1, w_loaded=0, out_valid=0, out_sum=0; in_valid pulses produce no output.
- SPLIT:
  - Stimulus: load weights 1..10 (row0 1..5, row1 6..10), then 5 beats of all-ones.
  - Required: out_valid exactly 3 cycles after the 5th beat, row0=15, row1=40.
  - Required: no out_valid before that; a 6th all-ones beat gives the same values on the next cycle.
- SINGLE:
  - Stimulus: same weights and data.
  - Required: slice0=55, slice1=0.
  - Stimulus: all weights -128, all data -128.
  - Required: slice0=163840 (20-bit signed), no overflow.
- STRIDE2:
  - Stimulus: row0 weights all 1; beats (1,2),(3,4),(5,6).
  - Required: row0=20 three cycles after the 3rd beat.
  - Stimulus: next beat (7,8).
  - Required: row0=30.
- clear:
  - Stimulus: clear coincident with in_valid one cycle after the beat that fills the window.
  - Required: no out_valid follows; next cycle w_ready=1, w_loaded=0; a reload gives w_idx starting at 0.
- Weight handshake:
  - Stimulus: w_valid toggled with gaps during LOAD.
  - Required: only accepted words count; w_loaded rises exactly after the 10th accept.
  - Stimulus: w_valid during RUN.
  - Required: weights unchanged.
